// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: segment codes,
// scan FSM state encoding and the hex-to-segment lookup.
package seg7_pkg;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_DEAD = 1'b1
  } state_t;

  // Active-high patterns, bit order {dp,g,f,e,d,c,b,a}.
  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [7:0] SEG_0   = 8'h3F;
  localparam logic [7:0] SEG_1   = 8'h06;
  localparam logic [7:0] SEG_2   = 8'h5B;
  localparam logic [7:0] SEG_3   = 8'h4F;
  localparam logic [7:0] SEG_4   = 8'h66;
  localparam logic [7:0] SEG_5   = 8'h6D;
  localparam logic [7:0] SEG_6   = 8'h7D;
  localparam logic [7:0] SEG_7   = 8'h07;
  localparam logic [7:0] SEG_8   = 8'h7F;
  localparam logic [7:0] SEG_9   = 8'h6F;
  localparam logic [7:0] SEG_A   = 8'h77;
  localparam logic [7:0] SEG_B   = 8'h7C;
  localparam logic [7:0] SEG_C   = 8'h39;
  localparam logic [7:0] SEG_D   = 8'h5E;
  localparam logic [7:0] SEG_E   = 8'h79;
  localparam logic [7:0] SEG_F   = 8'h71;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0:    return SEG_0;
      4'h1:    return SEG_1;
      4'h2:    return SEG_2;
      4'h3:    return SEG_3;
      4'h4:    return SEG_4;
      4'h5:    return SEG_5;
      4'h6:    return SEG_6;
      4'h7:    return SEG_7;
      4'h8:    return SEG_8;
      4'h9:    return SEG_9;
      4'hA:    return SEG_A;
      4'hB:    return SEG_B;
      4'hC:    return SEG_C;
      4'hD:    return SEG_D;
      4'hE:    return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble + decimal point to active-high segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg = hex_to_seg(nibble) | {dp, 7'b0000000};
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD_CYC       = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int CNT_MAX = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  SCAN_TC  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  DEAD_TC  = CNT_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_IDLE = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_next;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   disp_data_q, disp_data_d, pend_data_q, pend_data_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]     disp_blank_q, disp_blank_d, pend_blank_q, pend_blank_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     dig_q, dig_d;
  logic                  frame_done_q, frame_done_d;
  logic                  wrap;
  logic [DIGITS-1:0]     lz_mask;
  logic [3:0]            sel_nibble;
  logic                  sel_dp;
  logic                  sel_dark;
  logic [7:0]            seg_raw;
  logic [7:0]            lit_pat;
  logic [DIGITS-1:0]     onehot;

  assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    wrap    = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_TC) begin
          cnt_d = '0;
          if (DEAD_CYC == 0) begin
            idx_d = idx_next;
            wrap  = (idx_q == LAST_IDX);
          end else begin
            state_d = ST_DEAD;
          end
        end
      end
      default: begin
        if (cnt_q == DEAD_TC) begin
          cnt_d   = '0;
          state_d = ST_SCAN;
          idx_d   = idx_next;
          wrap    = (idx_q == LAST_IDX);
        end
      end
    endcase
  end

  // The swap reads the pending buffer as it was before this cycle, so a load
  // landing on the boundary stays pending for the following frame.
  always_comb begin
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_vld_d   = pend_vld_q;
    if (wrap && pend_vld_q) begin
      disp_data_d  = pend_data_q;
      disp_dp_d    = pend_dp_q;
      disp_blank_d = pend_blank_q;
      pend_vld_d   = 1'b0;
    end
    if (load) begin
      pend_data_d  = data_in;
      pend_dp_d    = dp_in;
      pend_blank_d = blank_in;
      pend_vld_d   = 1'b1;
    end
    frame_done_d = wrap;
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  always_comb begin : lz_scan
    logic run;
    lz_mask = '0;
    run     = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (run && (disp_data_q[4*i +: 4] == 4'h0) && !disp_dp_q[i]) lz_mask[i] = 1'b1;
      else run = 1'b0;
    end
  end
`else
  assign lz_mask = '0;
`endif

  assign sel_nibble = disp_data_q[{idx_q, 2'b00} +: 4];
  assign sel_dp     = disp_dp_q[idx_q];
  assign sel_dark   = disp_blank_q[idx_q] | lz_mask[idx_q];
  assign onehot     = DIGITS'(1) << idx_q;

  seg7_hex_decode u_dec (
    .nibble (sel_nibble),
    .dp     (sel_dp),
    .seg    (seg_raw)
  );

  // A dark digit keeps its select asserted so all digits share one duty cycle.
  always_comb begin
    lit_pat = sel_dark ? SEG_OFF : seg_raw;
    seg_d   = SEG_IDLE;
    dig_d   = DIG_IDLE;
    if (state_q == ST_SCAN) begin
      seg_d = (SEG_ACTIVE_LOW != 0) ? ~lit_pat : lit_pat;
      dig_d = (DIG_ACTIVE_LOW != 0) ? ~onehot : onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SCAN;
      idx_q        <= '0;
      cnt_q        <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_vld_q   <= 1'b0;
      seg_q        <= SEG_IDLE;
      dig_q        <= DIG_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_vld_q   <= pend_vld_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_q;
  assign dig_sel    = dig_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: two instances (with and without dead-time)
// share stimulus; a frame-arithmetic reference model predicts the pins every cycle.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int SA = 4;
  localparam int DA = 1;
  localparam int SB = 1;
  localparam int DB = 0;
  localparam int FA = N * (SA + DA);
  localparam logic [12:0] PINS_OFF = {1'b0, 4'hF, 8'hFF};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [7:0]  seg_a, seg_b;
  logic [3:0]  dig_a, dig_b;
  logic        fd_a, fd_b;

  int errors = 0;
  int checks = 0;

  logic [7:0]  seg_tbl [16];
  int          pos [2];
  logic [15:0] m_disp_d [2];
  logic [15:0] m_pend_d [2];
  logic [3:0]  m_disp_p [2];
  logic [3:0]  m_pend_p [2];
  logic [3:0]  m_disp_b [2];
  logic [3:0]  m_pend_b [2];
  logic        m_pv [2];
  logic [12:0] q_a [$];
  logic [12:0] q_b [$];

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(N), .SCAN_DIV(SA), .DEAD_CYC(DA),
                     .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .seg_out(seg_a), .dig_sel(dig_a), .frame_done(fd_a)
  );

  seg7_scan_driver #(.DIGITS(N), .SCAN_DIV(SB), .DEAD_CYC(DB),
                     .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .seg_out(seg_b), .dig_sel(dig_b), .frame_done(fd_b)
  );

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got fd/dig/seg=%h required %h", name, $time, act, exp);
    end
  endtask

  // Predicts the pins that appear after the coming clock edge, then advances
  // the model by one cycle. pos counts cycles since reset release.
  task automatic model_step(input int i, input int s, input int d, output logic [12:0] e);
    int f, r, k;
    logic [3:0] lz;
    logic [7:0] pat;
    logic [3:0] oh;
    if (!rst_n) begin
      e = PINS_OFF;
      pos[i] = 0;
      m_disp_d[i] = '0; m_disp_p[i] = '0; m_disp_b[i] = '0;
      m_pend_d[i] = '0; m_pend_p[i] = '0; m_pend_b[i] = '0;
      m_pv[i] = 1'b0;
      return;
    end
    f = N * (s + d);
    r = pos[i] % f;
    k = r / (s + d);
    lz = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin
      int top;
      top = 0;
      for (int j = 0; j < N; j++)
        if (m_disp_d[i][4*j +: 4] != 4'h0 || m_disp_p[i][j]) top = j;
      for (int j = 1; j < N; j++)
        if (j > top) lz[j] = 1'b1;
    end
`endif
    if ((r % (s + d)) < s) begin
      pat = (m_disp_b[i][k] || lz[k]) ? 8'h00
          : (seg_tbl[m_disp_d[i][4*k +: 4]] | {m_disp_p[i][k], 7'b0000000});
      oh  = 4'(1 << k);
      e   = {1'b0, ~oh, ~pat};
    end else begin
      e = PINS_OFF;
    end
    if (r == f - 1) begin
      e[12] = 1'b1;
      if (m_pv[i]) begin
        m_disp_d[i] = m_pend_d[i];
        m_disp_p[i] = m_pend_p[i];
        m_disp_b[i] = m_pend_b[i];
        m_pv[i] = 1'b0;
      end
    end
    if (load) begin
      m_pend_d[i] = data_in;
      m_pend_p[i] = dp_in;
      m_pend_b[i] = blank_in;
      m_pv[i] = 1'b1;
    end
    pos[i]++;
  endtask

  task automatic step(input logic rn, input logic ld, input logic [15:0] d,
                      input logic [3:0] dp, input logic [3:0] bl);
    logic [12:0] ea, eb;
    @(negedge clk);
    rst_n = rn; load = ld; data_in = d; dp_in = dp; blank_in = bl;
    model_step(0, SA, DA, ea);
    model_step(1, SB, DB, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++)
      step(1'b1, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic wait_phase(input int ph);
    for (int c = 0; c < FA && (pos[0] % FA) != ph; c++) idle(1);
  endtask

  initial begin : monitor
    logic [12:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("pins_a", {fd_a, dig_a, seg_a}, e);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("pins_b", {fd_b, dig_b, seg_b}, e);
      end
    end
  end

  initial begin : driver
    logic [15:0] rd;
    seg_tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    check("reset_pins_a", {fd_a, dig_a, seg_a}, PINS_OFF);
    check("reset_pins_b", {fd_b, dig_b, seg_b}, PINS_OFF);

    idle(2 * FA);

    wait_phase(7);
    step(1'b1, 1'b1, 16'h1234, 4'b0010, 4'b0000);
    idle(2 * FA + 5);

    wait_phase(1);
    step(1'b1, 1'b1, 16'hAAAA, 4'b0000, 4'b0000);
    idle(4);
    step(1'b1, 1'b1, 16'h5A5A, 4'b0000, 4'b0000);
    wait_phase(FA - 1);
    step(1'b1, 1'b1, 16'hFFFF, 4'b0000, 4'b0000);
    idle(3 * FA);

    wait_phase(2);
    step(1'b1, 1'b1, 16'h8888, 4'b0000, 4'b0100);
    idle(2 * FA + 5);

    wait_phase(2);
    step(1'b1, 1'b1, 16'h0040, 4'b0000, 4'b0000);
    idle(2 * FA + 5);

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 24) == 0) begin
        rd = 16'($urandom) >> $urandom_range(0, 16);
        step(1'b1, 1'b1, rd,
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
      end else begin
        idle(1);
      end
    end

    wait_phase(5);
    step(1'b1, 1'b1, 16'h9876, 4'b1000, 4'b0000);
    idle(3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_a", {fd_a, dig_a, seg_a}, PINS_OFF);
    check("async_reset_b", {fd_b, dig_b, seg_b}, PINS_OFF);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(3 * FA);

    @(posedge clk);
    #2;
    check("queue_drain", 13'(q_a.size() + q_b.size()), 13'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Multi-digit, time-multiplexed seven-segment display driver. It takes a packed vector of BCD/hex nibbles, decodes each nibble to segment patterns, and scans the digit enables at a programmable rate, with dead-time between digits to suppress ghosting. New display values are double-buffered and take effect only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between counter/datapath logic and the board's display pins, and supersedes per-digit combinational decoders.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 50000, clock cycles each digit stays lit (>=1)
DEAD_CYC, 2, clock cycles with all digits off between digits (>=0; 0 disables dead-time)
SEG_ACTIVE_LOW, 1, 1 = segment pins active-low (common anode); 0 = active-high
DIG_ACTIVE_LOW, 1, 1 = digit-select pins active-low; 0 = active-high

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data_in  in  4*DIGITS  nibble i = data_in[4i+3:4i]; digit 0 is least significant (rightmost)
dp_in  in  DIGITS  decimal point per digit, active-high
blank_in  in  DIGITS  force digit dark, active-high
load  in  1  capture data_in/dp_in/blank_in into the pending buffer
seg_out  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
dig_sel  out  DIGITS  one-hot digit enable, polarity per DIG_ACTIVE_LOW
frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Single clock domain (clk). rst_n is asynchronous assert, synchronous deassert, handled by the upstream reset synchroniser.
- Reset values: seg_out = all segments off; dig_sel = all digits off; frame_done = 0; digit index = 0; counter = 0; display and pending buffers = 0; pending_valid = 0; state = SCAN.
- FSM states:
  - SCAN: digit idx lit. Counter runs 0..SCAN_DIV-1. At terminal count, go to DEAD (or, if DEAD_CYC=0, directly to SCAN with the next idx).
  - DEAD: all digits off. Counter runs 0..DEAD_CYC-1. At terminal count, go to SCAN with idx+1.
- idx wraps from DIGITS-1 to 0. A frame is DIGITS*(SCAN_DIV+DEAD_CYC) cycles.
- Frame boundary: the cycle in which idx wraps to 0.
  - frame_done = 1 for that cycle.
  - If pending_valid = 1: display buffer <= pending buffer and pending_valid <= 0.
- load: pending buffer <= inputs and pending_valid <= 1. Repeated loads within a frame keep only the last one.
- load in the boundary cycle: the swap uses the pending contents from before that cycle. The new value stays pending until the next frame.
- Decode (active-high, before polarity), hex 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. dp maps to bit 7.
- A blanked digit shows all segments off, including dp. Its dig_sel stays asserted so every digit keeps the same duty cycle.
- Outputs are registered: pins reflect the state/idx from the previous cycle (1-cycle latency).
- During DEAD, seg_out is off and dig_sel is off.
- Reset mid-frame: immediate return to reset values and all pending data is lost.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- When defined: starting at digit DIGITS-1 and moving down, every digit whose displayed nibble is 0 and whose dp is 0 is blanked, until the first non-zero nibble or set dp is reached. Digit 0 is never blanked by this rule.
- The blanking is evaluated on the display buffer, so it changes only at frame boundaries.
- When undefined: zeros are shown normally; only blank_in blanks a digit.

Decomposition:
- Package seg7_pkg holds:
  - localparam segment codes SEG_0..SEG_F and SEG_OFF;
  - state encoding ST_SCAN / ST_DEAD;
  - function hex_to_seg(nibble).
- One sub-module: seg7_hex_decode, a combinational nibble + dp -> 8-bit active-high pattern. It is instantiated once, on the selected digit.

Test Plan:
1. DIGITS=4, SCAN_DIV=4, DEAD_CYC=1 (both polarities 1), reset released with no load -> dig_sel cycles 1110,1111,1101,1111,1011,1111,0111,1111 (4/1/4/1 cycle pattern), seg_out=C0 whenever a digit is lit, frame_done every 20 cycles.
2. load with data_in=16'h1234, dp_in=0010 mid-frame -> old value shown until frame_done. Next frame shows digit0=99 (4), digit1=30 (3 with dp), digit2=A4 (2), digit3=F9 (1).
3. Two loads (16'hAAAA, then 16'h5A5A) in one frame, plus a third load 16'hFFFF in the boundary cycle -> next frame shows 5A5A. The frame after that shows FFFF.
4. blank_in=0100 with data 16'h8888 -> digit2 seg_out=FF while its dig_sel is low. Other digits show 80.
5. DEAD_CYC=0, SCAN_DIV=1 -> dig_sel changes every cycle, no all-off cycles, frame_done every 4 cycles.
6. rst_n pulsed low mid-frame after a load -> seg_out=FF and dig_sel=1111 asynchronously. After release, the display shows 0000 and the pending value is discarded. With SEG7_LEADING_ZERO_BLANK_EN, data 16'h0040 -> digits 3 and 2 dark, digits 1/0 show 4/0.
